// File: rtl/fitof_pipe_pkg.sv
// Shared FPU definitions: single-precision field widths, bias and packing helper.
package fitof_pipe_pkg;

  localparam int EXP_BIAS = 127;
  localparam int FLOAT_W  = 32;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  // Exponent of a value whose leading one sits at bit 31 of a 32-bit integer.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + FLOAT_W - 1);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

  function automatic float_t pack_float(input logic sign,
                                        input logic [EXP_W-1:0] exp,
                                        input logic [MANT_W-1:0] mant);
    float_t f;
    f.sign = sign;
    f.exp  = exp;
    f.mant = mant;
    return f;
  endfunction

endpackage

// File: rtl/fitof_pipe_if.sv
// Operand/result handshake bundle for the integer-to-float converter.
interface fitof_pipe_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_inexact;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_inexact
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_inexact
  );
endinterface

// File: rtl/fitof_pipe_lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] x,
  output logic [5:0]  count
);

  // Ascending scan: the highest set bit is the last one to overwrite count.
  always_comb begin
    count = 6'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (x[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fitof_pipe.sv
// Three-stage integer to IEEE-754 single converter, round-to-nearest-even,
// with valid/ready handshake and a pass-through tag.
module fitof_pipe
  import fitof_pipe_pkg::*;
#(
  parameter bit SIGNED = 1'b1,
  parameter int TAG_W  = 5
) (
  input logic         clk,
  input logic         rstn,
  fitof_pipe_if.slave bus
);

  logic advance;
  logic out_valid_q;
  assign advance      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = advance;

  // S1: sign and magnitude
  logic             sign_in;
  logic [31:0]      mag_in;
  logic             s1_valid;
  logic             s1_sign;
  logic [31:0]      s1_mag;
  logic [TAG_W-1:0] s1_tag;

  assign sign_in = SIGNED & bus.in_x[31];
  assign mag_in  = sign_in ? (~bus.in_x + 32'd1) : bus.in_x;

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_tag   <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= sign_in;
      s1_mag   <= mag_in;
      s1_tag   <= bus.in_tag;
    end
  end

  // S2: normalise
  logic [5:0]       lz;
  logic             s2_valid;
  logic             s2_sign;
  logic [5:0]       s2_lz;
  logic [31:0]      s2_norm;
  logic [TAG_W-1:0] s2_tag;

  lzc32 u_lzc (
    .x     (s1_mag),
    .count (lz)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_lz    <= '0;
      s2_norm  <= '0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_lz    <= lz;
      s2_norm  <= s1_mag << lz;
      s2_tag   <= s1_tag;
    end
  end

  // S3: round and pack. A zero operand is the only case where the
  // normalised value has no leading one, so the zero flag is not carried.
  logic              zero;
  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   mant_sum;
  logic [EXP_W-1:0]  exp_base;
  float_t            res;
  logic              inexact;

  always_comb begin
    zero     = ~s2_norm[31];
    mant     = s2_norm[30:8];
    guard    = s2_norm[7];
    sticky   = |s2_norm[6:0];
    round_up = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    exp_base = EXP_TOP - {2'b00, s2_lz};
    res      = pack_float(s2_sign, exp_base + {{(EXP_W-1){1'b0}}, mant_sum[MANT_W]},
                          mant_sum[MANT_W-1:0]);
    inexact  = guard | sticky;
    if (zero) begin
      res     = '0;
      inexact = 1'b0;
    end
  end

  logic [31:0]      y_q;
  logic [TAG_W-1:0] tag_q;
  logic             inexact_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      tag_q       <= '0;
      inexact_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid;
      y_q         <= res;
      tag_q       <= s2_tag;
      inexact_q   <= inexact;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_y       = y_q;
  assign bus.out_tag     = tag_q;
  assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_fitof_pipe.sv
// Directed scoreboard bench for fitof_pipe: signed and unsigned instances.
module tb_fitof_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fitof_pipe_if #(.TAG_W(5)) a_if ();
  fitof_pipe_if #(.TAG_W(5)) b_if ();

  fitof_pipe #(.SIGNED(1'b1), .TAG_W(5)) dut_a (
    .clk  (clk),
    .rstn (rst),
    .bus  (a_if)
  );

  fitof_pipe #(.SIGNED(1'b0), .TAG_W(5)) dut_b (
    .clk  (clk),
    .rstn (rst),
    .bus  (b_if)
  );

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        inx;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t pend_a, pend_b;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b0;
  bit   acc_a, acc_b;
  logic [31:0] held_y;
  logic [4:0]  held_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_a();
    exp_t e;
    if (qa.size() == 0) begin
      check("unexpected_out_a", 32'(a_if.out_valid), 32'd0);
    end else begin
      e = qa.pop_front();
      check("y_a", a_if.out_y, e.y);
      check("tag_a", 32'(a_if.out_tag), 32'(e.tag));
      check("inexact_a", 32'(a_if.out_inexact), 32'(e.inx));
      if (chk_lat) check("latency_a", 32'(cyc - e.cyc), 32'd3);
    end
  endtask

  task automatic pop_b();
    exp_t e;
    if (qb.size() == 0) begin
      check("unexpected_out_b", 32'(b_if.out_valid), 32'd0);
    end else begin
      e = qb.pop_front();
      check("y_b", b_if.out_y, e.y);
      check("tag_b", 32'(b_if.out_tag), 32'(e.tag));
      check("inexact_b", 32'(b_if.out_inexact), 32'(e.inx));
    end
  endtask

  // One clock: record accepts and transfers before the edge, then step.
  task automatic tick();
    exp_t e;
    #1;
    acc_a = a_if.in_valid && a_if.in_ready;
    acc_b = b_if.in_valid && b_if.in_ready;
    if (acc_a) begin e = pend_a; e.cyc = cyc; qa.push_back(e); end
    if (acc_b) begin e = pend_b; e.cyc = cyc; qb.push_back(e); end
    if (a_if.out_valid && a_if.out_ready) pop_a();
    if (b_if.out_valid && b_if.out_ready) pop_b();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input bit sel, input logic [31:0] x, input logic [4:0] tag,
                      input logic [31:0] y, input logic inx);
    bit done = 1'b0;
    if (sel) begin
      b_if.in_valid = 1'b1; b_if.in_x = x; b_if.in_tag = tag;
      pend_b = '{y, tag, inx, 0};
    end else begin
      a_if.in_valid = 1'b1; a_if.in_x = x; a_if.in_tag = tag;
      pend_a = '{y, tag, inx, 0};
    end
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      done = sel ? acc_b : acc_a;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.in_x = '0; a_if.in_tag = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_x = '0; b_if.in_tag = '0; b_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_out_y", a_if.out_y, 32'd0);
    check("rst_out_tag", 32'(a_if.out_tag), 32'd0);
    check("rst_out_inexact", 32'(a_if.out_inexact), 32'd0);
    check("rst_in_ready", 32'(a_if.in_ready), 32'd1);
    a_if.out_ready = 1'b1;

    // Basic values, back-to-back, latency checked
    chk_lat = 1'b1;
    send(1'b0, 32'd1,          5'd1, 32'h3F800000, 1'b0);
    send(1'b0, 32'hFFFFFFFF,   5'd2, 32'hBF800000, 1'b0);
    send(1'b0, 32'd0,          5'd3, 32'h00000000, 1'b0);
    send(1'b0, 32'd100,        5'd4, 32'h42C80000, 1'b0);
    send(1'b0, 32'd5,          5'd5, 32'h40A00000, 1'b0);
    drain();

    // Extremes
    send(1'b0, 32'h80000000,   5'd6, 32'hCF000000, 1'b0);
    send(1'b0, 32'h7FFFFFFF,   5'd7, 32'h4F000000, 1'b1);
    // Ties to even
    send(1'b0, 32'd16777217,   5'd8, 32'h4B800000, 1'b1);
    send(1'b0, 32'd16777219,   5'd9, 32'h4B800002, 1'b1);
    send(1'b0, 32'd16777218,   5'd10, 32'h4B800001, 1'b0);
    drain();

    // Backpressure: three fill the pipe, the fourth waits
    chk_lat = 1'b0;
    a_if.out_ready = 1'b0;
    send(1'b0, 32'd2, 5'd11, 32'h40000000, 1'b0);
    send(1'b0, 32'd3, 5'd12, 32'h40400000, 1'b0);
    send(1'b0, 32'd4, 5'd13, 32'h40800000, 1'b0);
    check("bp_out_valid", 32'(a_if.out_valid), 32'd1);
    held_y   = a_if.out_y;
    held_tag = a_if.out_tag;
    a_if.in_valid = 1'b1; a_if.in_x = 32'd6; a_if.in_tag = 5'd14;
    pend_a = '{32'h40C00000, 5'd14, 1'b0, 0};
    for (int n = 0; n < 5; n++) begin
      tick();
      check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
      check("bp_out_y_stable", a_if.out_y, held_y);
      check("bp_out_tag_stable", 32'(a_if.out_tag), 32'(held_tag));
    end
    a_if.out_ready = 1'b1;
    tick();
    check("bp_late_accept", 32'(acc_a), 32'd1);
    a_if.in_valid = 1'b0;
    drain();

    // Unsigned instance
    send(1'b1, 32'hFFFFFFFF, 5'd15, 32'h4F800000, 1'b1);
    send(1'b1, 32'h80000000, 5'd16, 32'h4F000000, 1'b0);
    send(1'b1, 32'd1,        5'd17, 32'h3F800000, 1'b0);
    drain();

    // Reset mid-flight drops in-flight operands
    send(1'b0, 32'd7, 5'd18, 32'h40E00000, 1'b0);
    send(1'b0, 32'd9, 5'd19, 32'h41100000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    rst = 1'b0;
    check("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
    for (int n = 0; n < 8; n++) tick();
    send(1'b0, 32'hFFFFFFFE, 5'd20, 32'hC0000000, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
